fp_mul_exp_path: RTL and testbench
==================================

Name: fp_mul_exp_path

Overview:
- Registered exponent/flag/rounding datapath for the single-precision FP multiplier.
- Built from three shared leaf units: an 8-bit magnitude comparator, an 8-bit ripple adder with carry-out, and a 24-bit adder.
- Takes the two operand exponents, the normalise flag and the truncated product mantissa with its round bit.
- Produces the 9-bit biased result exponent, the exception/zero/overflow/underflow flags and the rounded 23-bit mantissa, one clock later.

Parameters:
- BIAS, 127, exponent bias subtracted from the exponent sum; 8-bit unsigned, range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- valid_in  in  1  input sample valid.
- ex_a  in  8  biased exponent of operand A.
- ex_b  in  8  biased exponent of operand B.
- normalised  in  1  1 = product MSB (bit 47) was set.
- mant_in  in  23  truncated normalised product mantissa.
- round_bit  in  1  round increment, pre-computed upstream.
- valid_out  out  1  result valid.
- exponent  out  9  result exponent, 9-bit two's-complement wrap.
- exception  out  1  ex_a==8'hFF or ex_b==8'hFF.
- zero  out  1  zero operand present.
- overflow  out  1  exponent beyond 255.
- underflow  out  1  exponent negative.
- mant_out  out  23  rounded mantissa.
- mant_carry  out  1  carry out of the rounding add.

Behaviour:
- Reset: while rst_n=0, every output is 0, asynchronously, including valid_out, exponent and all flags. First capture happens on the first rising edge after release.
- Latency 1: every rising edge registers all outputs from the current inputs.
  - valid_out <= valid_in.
  - Data registers also load when valid_in=0, so datapath outputs are don't-care while valid_out=0.
- No backpressure and no handshake beyond valid.
- Exponent arithmetic:
  - sum[8:0] = ex_a + ex_b, using the 8-bit adder with carry-in 0; carry-out goes to sum[8].
  - adj = BIAS - normalised, zero-extended to 9 bits.
  - exponent = sum - adj, modulo 512.
- Flags, all from four comparator instances (ex_a/ex_b against 8'hFF and 8'h00, each using its eq output):
  - exception = (ex_a==8'hFF) | (ex_b==8'hFF).
  - zero = !exception & ((ex_a==0) | (ex_b==0)); exception has priority over zero.
  - overflow = exponent[8] & !exponent[7] & !zero.
  - underflow = exponent[8] & exponent[7] & !zero.
  - overflow and underflow are never both 1.
  - overflow/underflow are NOT masked by exception; downstream result selection applies that priority.
- Rounding: {mant_carry, mant_out} = {1'b0, mant_in} + {23'd0, round_bit}, using the 24-bit adder with carry-in 0.
  - mant_in=23'h7FFFFF with round_bit=1 gives mant_out=0 and mant_carry=1.
  - The exponent is not adjusted for this carry.
- Boundaries:
  - ex_a=ex_b=8'hFF: sum=0x1FE; exception=1, zero=0.
  - Both exponents 0: zero=1, and overflow/underflow are forced 0.
  - Reset asserted mid-stream: valid_out drops immediately and the in-flight sample is discarded.

Optional Feature:
- INPUT_REG_EN defined: an input register stage captures valid_in, ex_a, ex_b, normalised, mant_in and round_bit on each edge; latency becomes 2 cycles. That stage also resets to 0 asynchronously.
- INPUT_REG_EN undefined: inputs feed the combinational logic directly; latency 1.

Test Plan:
- ex_a=0x84, ex_b=0x84, normalised=1, valid_in=1 -> next cycle: exponent=0x08A, all flags 0, valid_out=1.
- ex_a=0x80, ex_b=0x82, normalised=1 -> exponent=0x084; then ex_a=0x82, ex_b=0x84 -> exponent=0x088. Back-to-back issue, one result per cycle.
- ex_a=0x04, ex_b=0x04, normalised=1 -> exponent=0x18A, underflow=1, overflow=0. Then ex_a=0xFE, ex_b=0xFE, normalised=0 -> exponent=0x17D, overflow=1.
- ex_a=0xFF, ex_b=0x00 -> exception=1, zero=0. Then ex_a=0x00, ex_b=0x85 -> zero=1, exception=0, underflow=0.
- mant_in=0x7FFFFF, round_bit=1 -> mant_out=0, mant_carry=1. mant_in=0x123456, round_bit=1 -> mant_out=0x123457, mant_carry=0.
- Assert rst_n=0 mid-stream with valid_in=1 -> all outputs 0 immediately. Release -> first valid_out one cycle later (two with INPUT_REG_EN).

Source files
------------

// File: rtl/fp_mul_exp_path.sv
// rtl/fp_mul_exp_path.sv - FP multiplier exponent/flag/rounding path, one registered stage.
// Optional input register stage when INPUT_REG_EN is defined (latency 2 instead of 1).

module cmp8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);
    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);
endmodule

module add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic c;

    always_comb begin
        c   = cin;
        sum = 8'd0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module add24 (
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        cin,
    output logic [23:0] sum
);
    assign sum = a + b + {23'd0, cin};
endmodule

module fp_mul_exp_path #(
    parameter logic [7:0] BIAS = 8'd127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [7:0]  ex_a,
    input  logic [7:0]  ex_b,
    input  logic        normalised,
    input  logic [22:0] mant_in,
    input  logic        round_bit,
    output logic        valid_out,
    output logic [8:0]  exponent,
    output logic        exception,
    output logic        zero,
    output logic        overflow,
    output logic        underflow,
    output logic [22:0] mant_out,
    output logic        mant_carry
);
    logic        s_valid;
    logic [7:0]  s_ex_a;
    logic [7:0]  s_ex_b;
    logic        s_norm;
    logic [22:0] s_mant;
    logic        s_round;

`ifdef INPUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_ex_a  <= 8'd0;
            s_ex_b  <= 8'd0;
            s_norm  <= 1'b0;
            s_mant  <= 23'd0;
            s_round <= 1'b0;
        end else begin
            s_valid <= valid_in;
            s_ex_a  <= ex_a;
            s_ex_b  <= ex_b;
            s_norm  <= normalised;
            s_mant  <= mant_in;
            s_round <= round_bit;
        end
    end
`else
    assign s_valid = valid_in;
    assign s_ex_a  = ex_a;
    assign s_ex_b  = ex_b;
    assign s_norm  = normalised;
    assign s_mant  = mant_in;
    assign s_round = round_bit;
`endif

    logic [7:0]  sum_lo;
    logic        sum_c;
    logic [8:0]  sum;
    logic [8:0]  adj;
    logic [8:0]  exp_c;
    logic        a_max, b_max, a_min, b_min;
    logic [7:0]  unused_cmp;
    logic        exc_c, zero_c, ovf_c, unf_c;
    logic [23:0] round_sum;

    add8 u_exp_add (.a(s_ex_a), .b(s_ex_b), .cin(1'b0), .sum(sum_lo), .cout(sum_c));

    assign sum   = {sum_c, sum_lo};
    assign adj   = {1'b0, BIAS} - {8'd0, s_norm};
    assign exp_c = sum - adj;

    cmp8 u_cmp_a_max (.a(s_ex_a), .b(8'hFF), .eq(a_max), .gt(unused_cmp[0]), .lt(unused_cmp[1]));
    cmp8 u_cmp_b_max (.a(s_ex_b), .b(8'hFF), .eq(b_max), .gt(unused_cmp[2]), .lt(unused_cmp[3]));
    cmp8 u_cmp_a_min (.a(s_ex_a), .b(8'h00), .eq(a_min), .gt(unused_cmp[4]), .lt(unused_cmp[5]));
    cmp8 u_cmp_b_min (.a(s_ex_b), .b(8'h00), .eq(b_min), .gt(unused_cmp[6]), .lt(unused_cmp[7]));

    // A zero operand suppresses the range flags; exception does not.
    assign exc_c  = a_max | b_max;
    assign zero_c = !exc_c & (a_min | b_min);
    assign ovf_c  = exp_c[8] & !exp_c[7] & !zero_c;
    assign unf_c  = exp_c[8] & exp_c[7] & !zero_c;

    add24 u_round_add (.a({1'b0, s_mant}), .b({23'd0, s_round}), .cin(1'b0), .sum(round_sum));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            exponent   <= 9'd0;
            exception  <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            mant_out   <= 23'd0;
            mant_carry <= 1'b0;
        end else begin
            valid_out  <= s_valid;
            exponent   <= exp_c;
            exception  <= exc_c;
            zero       <= zero_c;
            overflow   <= ovf_c;
            underflow  <= unf_c;
            mant_out   <= round_sum[22:0];
            mant_carry <= round_sum[23];
        end
    end
endmodule

// File: tb/tb_fp_mul_exp_path.sv
// tb/tb_fp_mul_exp_path.sv - scoreboard bench for fp_mul_exp_path.

module tb_fp_mul_exp_path;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [7:0]  ex_a = 8'd0;
    logic [7:0]  ex_b = 8'd0;
    logic        normalised = 1'b0;
    logic [22:0] mant_in = 23'd0;
    logic        round_bit = 1'b0;
    logic        valid_out;
    logic [8:0]  exponent;
    logic        exception, zero, overflow, underflow;
    logic [22:0] mant_out;
    logic        mant_carry;

`ifdef INPUT_REG_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 1;
`endif

    typedef struct packed {
        logic [8:0]  e;
        logic [3:0]  flags;
        logic [23:0] m;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    fp_mul_exp_path dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ex_a(ex_a), .ex_b(ex_b),
        .normalised(normalised), .mant_in(mant_in), .round_bit(round_bit),
        .valid_out(valid_out), .exponent(exponent), .exception(exception), .zero(zero),
        .overflow(overflow), .underflow(underflow), .mant_out(mant_out), .mant_carry(mant_carry)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic n,
                                   input logic [22:0] m, input logic r);
        exp_t x;
        logic [8:0] s;
        logic exc, z;
        s   = {1'b0, a} + {1'b0, b};
        x.e = s - (9'd127 - {8'd0, n});
        exc = (a == 8'hFF) || (b == 8'hFF);
        z   = !exc && ((a == 8'h00) || (b == 8'h00));
        x.flags = {exc, z, x.e[8] & ~x.e[7] & ~z, x.e[8] & x.e[7] & ~z};
        x.m = {1'b0, m} + {23'd0, r};
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_out();
        exp_t x;
        if (valid_out === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                x = q.pop_front();
                chk("exponent", {23'd0, exponent}, {23'd0, x.e});
                chk("flags", {28'd0, exception, zero, overflow, underflow}, {28'd0, x.flags});
                chk("mant", {8'd0, mant_carry, mant_out}, {8'd0, x.m});
            end
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic n,
                         input logic [22:0] m, input logic r, input logic v);
        valid_in = v; ex_a = a; ex_b = b; normalised = n; mant_in = m; round_bit = r;
        if (v) q.push_back(model(a, b, n, m, r));
        @(posedge clk); #1;
        check_out();
    endtask

    initial begin
        int lat;
        #12;
        chk("reset_valid", {31'd0, valid_out}, 32'd0);
        chk("reset_data", {exponent, exception, zero, overflow, underflow, mant_carry}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        drive(8'h84, 8'h84, 1'b1, 23'h000100, 1'b0, 1'b1);
        drive(8'h80, 8'h82, 1'b1, 23'h000000, 1'b0, 1'b1);
        drive(8'h82, 8'h84, 1'b1, 23'h000001, 1'b1, 1'b1);
        drive(8'h04, 8'h04, 1'b1, 23'h0000AA, 1'b0, 1'b1);
        drive(8'hFE, 8'hFE, 1'b0, 23'h000000, 1'b0, 1'b1);
        drive(8'hFF, 8'h00, 1'b0, 23'h000000, 1'b0, 1'b1);
        drive(8'h00, 8'h85, 1'b1, 23'h000000, 1'b0, 1'b1);
        drive(8'hFF, 8'hFF, 1'b1, 23'h000000, 1'b0, 1'b1);
        drive(8'h00, 8'h00, 1'b0, 23'h000000, 1'b0, 1'b1);
        drive(8'h90, 8'h91, 1'b1, 23'h7FFFFF, 1'b1, 1'b1);
        drive(8'h70, 8'h71, 1'b0, 23'h123456, 1'b1, 1'b1);
        drive(8'h01, 8'h01, 1'b0, 23'h3ABCDE, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            drive(8'($urandom_range(1, 254)), 8'($urandom_range(1, 254)), 1'($urandom),
                  23'($urandom), 1'($urandom), 1'b1);
        drive(8'h00, 8'h00, 1'b0, 23'd0, 1'b0, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 23'd0, 1'b0, 1'b0);
        chk("queue_drained", q.size(), 32'd0);

        valid_in = 1'b1; ex_a = 8'h84; ex_b = 8'h84; normalised = 1'b1;
        mant_in = 23'h7FFFFF; round_bit = 1'b1;
        q.push_back(model(8'h84, 8'h84, 1'b1, 23'h7FFFFF, 1'b1));
        @(posedge clk); #1;
        check_out();
        #2; rst_n = 1'b0; #1;
        chk("midreset_valid", {31'd0, valid_out}, 32'd0);
        chk("midreset_data", {exponent, exception, zero, overflow, underflow, mant_carry}, 32'd0);
        chk("midreset_mant", {9'd0, mant_out}, 32'd0);
        q.delete();
        @(posedge clk); #1;
        chk("held_reset_valid", {31'd0, valid_out}, 32'd0);
        rst_n = 1'b1;

        valid_in = 1'b1; ex_a = 8'h80; ex_b = 8'h82; normalised = 1'b1;
        mant_in = 23'h000010; round_bit = 1'b0;
        q.push_back(model(8'h80, 8'h82, 1'b1, 23'h000010, 1'b0));
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            lat++;
            valid_in = 1'b0;
            if (valid_out === 1'b1) begin
                check_out();
                break;
            end
        end
        chk("release_latency", lat, EXP_LAT);
        chk("queue_final", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
